// File: rtl/fm_pkg.sv
// Shared constants, state type and sample-format helper for the FM audio path.
package fm_pkg;

    localparam int SYS_CLK_HZ      = 250_000_000;
    localparam int AUDIO_SAMPLE_HZ = 44100;
    localparam int SAMPLE_W        = 8;
    localparam logic [SAMPLE_W-1:0] OFFSET_BIN_MID = 8'h80;

    // Rounded clock divider for the audio rate (250 MHz / 44.1 kHz -> 5669).
    localparam int DEFAULT_SAMPLE_DIV = (SYS_CLK_HZ + AUDIO_SAMPLE_HZ / 2) / AUDIO_SAMPLE_HZ;

    typedef enum logic {
        ST_PREFILL = 1'b0,
        ST_PLAY    = 1'b1
    } pacer_state_t;

    function automatic logic [SAMPLE_W-1:0] offset_to_signed(input logic [SAMPLE_W-1:0] b);
        return b ^ OFFSET_BIN_MID;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is registered on pop
// (read-before-write, so a simultaneous push/pop while full returns the old entry).
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [WIDTH-1:0]    r_rdata;
    logic                w_push_ok;
    logic                w_pop_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_rdata;

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (w_pop_ok) begin
            r_rdata <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers bursty offset-binary UART audio bytes and releases them as signed
// samples at a fixed rate, with prefill gating and sticky underrun/overflow flags.
module audio_sample_pacer
    import fm_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int DEPTH_LOG2 = 6,
    parameter int PREFILL    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_dat,
    input  logic                  i_dat_vld,
    input  logic                  i_clr_flags,
    output logic [7:0]            o_sample,
    output logic                  o_sample_vld,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_playing,
    output logic                  o_underrun,
    output logic                  o_overflow
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    pacer_state_t        r_state;
    pacer_state_t        w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    logic                w_full;
    logic                w_empty;
    logic [DEPTH_LOG2:0] w_level;
    logic [7:0]          w_rdata;

    logic                w_tick;
    logic                w_pop;
    logic                w_underrun_set;
    logic                w_overflow_set;

    logic                r_sample_vld;
    logic                r_from_fifo;
    logic                r_underrun;
    logic                r_overflow;

    sync_fifo #(
        .WIDTH      (SAMPLE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_dat_vld),
        .i_wdata (i_dat),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_tick         = (r_state == ST_PLAY) && (r_cnt == CNT_LAST);
    assign w_pop          = w_tick && !w_empty;
    assign w_underrun_set = w_tick && w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_overflow_set = i_dat_vld && w_full && !w_pop;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            ST_PREFILL: begin
                if (w_level >= PREFILL_LVL) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (w_empty) begin
                        w_state_next = ST_PREFILL;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_PREFILL;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_PREFILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Flag set wins over a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample_vld <= 1'b0;
            r_from_fifo  <= 1'b0;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_sample_vld <= w_tick;
            if (w_pop) begin
                r_from_fifo <= 1'b1;
            end else if (w_underrun_set) begin
                r_from_fifo <= 1'b0;
            end
            r_underrun <= (r_underrun && !i_clr_flags) || w_underrun_set;
            r_overflow <= (r_overflow && !i_clr_flags) || w_overflow_set;
        end
    end

    // Underrun plays the carrier centre (0) rather than repeating stale data.
    assign o_sample     = r_from_fifo ? offset_to_signed(w_rdata) : '0;
    assign o_sample_vld = r_sample_vld;
    assign o_level      = w_level;
    assign o_playing    = (r_state == ST_PLAY);
    assign o_underrun   = r_underrun;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Self-checking bench: directed corner cases plus random traffic, all compared
// against a queue-based reference model of the pacer every cycle.
module tb_audio_sample_pacer;

    localparam int SAMPLE_DIV = 8;
    localparam int DEPTH_LOG2 = 3;
    localparam int PREFILL    = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                i_rst;
    logic [7:0]          i_dat;
    logic                i_dat_vld;
    logic                i_clr_flags;
    logic [7:0]          o_sample;
    logic                o_sample_vld;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_playing;
    logic                o_underrun;
    logic                o_overflow;

    audio_sample_pacer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .PREFILL    (PREFILL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_dat        (i_dat),
        .i_dat_vld    (i_dat_vld),
        .i_clr_flags  (i_clr_flags),
        .o_sample     (o_sample),
        .o_sample_vld (o_sample_vld),
        .o_level      (o_level),
        .o_playing    (o_playing),
        .o_underrun   (o_underrun),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a byte queue, a playing flag and the cycle playout began.
    logic [7:0] q[$];
    int         mcyc      = 0;
    int         mstart    = 0;
    bit         m_playing = 1'b0;
    bit         m_vld     = 1'b0;
    bit         m_under   = 1'b0;
    bit         m_over    = 1'b0;
    logic [7:0] m_sample  = 8'h00;

    typedef struct {
        logic [7:0] dat_in;
        logic [7:0] exp_sample;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic vld, input logic [7:0] dat, input logic clr);
        bit was_playing;
        bit tick;
        bit us;
        bit os;
        int lvl_before;
        if (rst) begin
            q.delete();
            m_playing = 1'b0;
            m_vld     = 1'b0;
            m_sample  = 8'h00;
            m_under   = 1'b0;
            m_over    = 1'b0;
        end else begin
            was_playing = m_playing;
            lvl_before  = q.size();
            tick = was_playing && (((mcyc - mstart) % SAMPLE_DIV) == SAMPLE_DIV - 1);
            us = 1'b0;
            os = 1'b0;
            m_vld = tick;
            if (tick) begin
                if (q.size() > 0) begin
                    m_sample = q.pop_front() ^ 8'h80;
                end else begin
                    m_sample  = 8'h00;
                    us        = 1'b1;
                    m_playing = 1'b0;
                end
            end
            if (vld) begin
                if (q.size() < DEPTH) q.push_back(dat);
                else os = 1'b1;
            end
            m_under = (m_under && !clr) || us;
            m_over  = (m_over && !clr) || os;
            if (!was_playing && lvl_before >= PREFILL) begin
                m_playing = 1'b1;
                mstart    = mcyc + 1;
            end
        end
        mcyc++;
    endtask

    function automatic bit model_tick_next();
        return m_playing && (((mcyc - mstart) % SAMPLE_DIV) == SAMPLE_DIV - 1);
    endfunction

    // One clock: drive inputs, step DUT and model together, compare #1 after the edge.
    task automatic cyc(input logic rst, input logic vld, input logic [7:0] dat, input logic clr);
        i_rst       = rst;
        i_dat_vld   = vld;
        i_dat       = dat;
        i_clr_flags = clr;
        @(posedge clk);
        model_step(rst, vld, dat, clr);
        #1;
        chk("sample",     32'(o_sample),     32'(m_sample));
        chk("sample_vld", 32'(o_sample_vld), 32'(m_vld));
        chk("level",      32'(o_level),      32'(q.size()));
        chk("playing",    32'(o_playing),    32'(m_playing));
        chk("underrun",   32'(o_underrun),   32'(m_under));
        chk("overflow",   32'(o_overflow),   32'(m_over));
        if (o_sample_vld) begin
            $display("t=%0t sample=%02h level=%0d underrun=%0b overflow=%0b",
                     $time, o_sample, o_level, o_underrun, o_overflow);
        end
    endtask

    task automatic wait_sample(input string name, output logic [7:0] s, output int n, output bit got);
        got = 1'b0;
        s   = 8'h00;
        n   = 0;
        for (int k = 0; k < 4 * SAMPLE_DIV && !got; k++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
            if (o_sample_vld) begin
                got = 1'b1;
                s   = o_sample;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_strobe required=strobe", name);
        end
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] exp_b[$];
        int         n;
        int         vcount;
        bit         got;

        tbl[0] = '{dat_in: 8'h80, exp_sample: 8'h00};
        tbl[1] = '{dat_in: 8'hFF, exp_sample: 8'h7F};
        tbl[2] = '{dat_in: 8'h00, exp_sample: 8'h80};
        tbl[3] = '{dat_in: 8'h81, exp_sample: 8'h01};

        i_rst = 1'b1; i_dat = 8'h00; i_dat_vld = 1'b0; i_clr_flags = 1'b0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_level",    32'(o_level),      0);
        chk("rst_playing",  32'(o_playing),    0);
        chk("rst_sample",   32'(o_sample),     0);
        chk("rst_vld",      32'(o_sample_vld), 0);
        chk("rst_underrun", 32'(o_underrun),   0);
        chk("rst_overflow", 32'(o_overflow),   0);

        // Prefill and start, table-driven conversion.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, tbl[i].dat_in, 1'b0);
        chk("c1_level4",      32'(o_level),   4);
        chk("c1_not_playing", 32'(o_playing), 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("c1_playing_rise", 32'(o_playing), 1);
        for (int i = 0; i < 4; i++) begin
            wait_sample("c1_sample", s, n, got);
            if (got) begin
                chk("c1_sample_val", 32'(s), 32'(tbl[i].exp_sample));
                chk("c1_spacing",    32'(n), SAMPLE_DIV);
            end
        end

        // Underrun after drain, then restart.
        wait_sample("c2_underrun", s, n, got);
        if (got) begin
            chk("c2_sample0",  32'(s),          0);
            chk("c2_underrun", 32'(o_underrun), 1);
            chk("c2_stopped",  32'(o_playing),  0);
            chk("c2_spacing",  32'(n),          SAMPLE_DIV);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("c2_restart", 32'(o_playing), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("c2_clear", 32'(o_underrun), 0);

        // Overflow: nine back-to-back pushes.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        chk("c3_level8",   32'(o_level),    8);
        chk("c3_overflow", 32'(o_overflow), 1);

        // Full FIFO, push aligned with a tick.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("c4_ovf_cleared", 32'(o_overflow), 0);
        for (int k = 0; k < 2 * SAMPLE_DIV && !model_tick_next(); k++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("c4_full_before", 32'(o_level), 8);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        chk("c4_level_stays", 32'(o_level),      8);
        chk("c4_no_overflow", 32'(o_overflow),   0);
        chk("c4_tick_vld",    32'(o_sample_vld), 1);
        chk("c4_first",       32'(o_sample),     32'h A0);
        exp_b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h55};
        foreach (exp_b[i]) begin
            wait_sample("c4_drain", s, n, got);
            if (got) chk("c4_order", 32'(s), 32'(exp_b[i] ^ 8'h80));
        end
        wait_sample("c3_tail", s, n, got);
        if (got) begin
            chk("c3_no_ninth",  32'(s),          0);
            chk("c3_underrun",  32'(o_underrun), 1);
        end

        // Clear vs set priority.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'h99, 1'b1);
        chk("c5_set_wins", 32'(o_overflow), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("c5_clear", 32'(o_overflow), 0);

        // Mid-play reset with five entries queued.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) wait_sample("c6_pre", s, n, got);
        chk("c6_pre_level",   32'(o_level),   5);
        chk("c6_pre_playing", 32'(o_playing), 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("c6_level",    32'(o_level),    0);
        chk("c6_playing",  32'(o_playing),  0);
        chk("c6_sample",   32'(o_sample),   0);
        chk("c6_overflow", 32'(o_overflow), 0);
        chk("c6_underrun", 32'(o_underrun), 0);
        vcount = 0;
        for (int k = 0; k < 3 * SAMPLE_DIV; k++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            if (o_sample_vld) vcount++;
        end
        chk("c6_no_vld", 32'(vcount), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        wait_sample("c6_resume", s, n, got);
        if (got) chk("c6_resume_val", 32'(s), 32'h40);

        // Random traffic: light load first, then heavy load.
        for (int k = 0; k < 3000; k++) begin
            int   rate;
            logic v;
            logic c;
            logic r;
            rate = (k < 1500) ? 10 : 5;
            v = ($urandom_range(rate - 1) == 0);
            c = ($urandom_range(39) == 0);
            r = ($urandom_range(599) == 0);
            cyc(r, v, 8'($urandom), c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
